// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: op-type encodings, default widths and the entry layout
// shared by the issue queue and its users.
package issue_queue_pkg;
    localparam int DEF_ROB_IDX_W = 5;
    localparam int DEF_TYPE_W    = 6;

    typedef enum logic [DEF_TYPE_W-1:0] {
        OP_ADD = 6'd0,
        OP_SUB = 6'd1,
        OP_AND = 6'd2,
        OP_OR  = 6'd3,
        OP_XOR = 6'd4,
        OP_SLL = 6'd5,
        OP_SRL = 6'd6,
        OP_SLT = 6'd7
    } iq_op_e;

    typedef struct packed {
        logic                     valid;
        logic [DEF_TYPE_W-1:0]    op;
        logic [DEF_ROB_IDX_W-1:0] rob_id;
        logic [31:0]              v1;
        logic [31:0]              v2;
        logic                     has_dep1;
        logic                     has_dep2;
        logic [DEF_ROB_IDX_W-1:0] dep1;
        logic [DEF_ROB_IDX_W-1:0] dep2;
    } iq_entry_t;
endpackage

// File: rtl/iq_age_select.sv
// iq_age_select: picks the oldest ready entry from an age matrix.
// i_age[i][j] set means entry j is older than entry i.
module iq_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
    input  logic [DEPTH-1:0]            i_ready,
    output logic [DEPTH-1:0]            o_oldest,
    output logic                        o_any
);
    always_comb begin
        o_oldest = '0;
        for (int i = 0; i < DEPTH; i++)
            o_oldest[i] = i_ready[i] && !(|(i_age[i] & i_ready));
    end

    assign o_any = |i_ready;
endmodule

// File: rtl/issue_queue.sv
// issue_queue: age-ordered issue queue with CDB wakeup. Define ISSUE_QUEUE_BYPASS_EN
// to capture same-cycle broadcasts at dispatch; otherwise dispatch stalls during broadcasts.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int NUM_CDB   = 2,
    parameter int ROB_IDX_W = DEF_ROB_IDX_W,
    parameter int TYPE_W    = DEF_TYPE_W,
    parameter int AF_MARGIN = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          flush_in,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [TYPE_W-1:0]             disp_type,
    input  logic [ROB_IDX_W-1:0]          disp_rob_id,
    input  logic [31:0]                   disp_v1,
    input  logic [31:0]                   disp_v2,
    input  logic [ROB_IDX_W-1:0]          disp_dep1,
    input  logic [ROB_IDX_W-1:0]          disp_dep2,
    input  logic                          disp_has_dep1,
    input  logic                          disp_has_dep2,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0]  cdb_rob_id,
    input  logic [NUM_CDB*32-1:0]         cdb_val,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [TYPE_W-1:0]             iss_type,
    output logic [ROB_IDX_W-1:0]          iss_rob_id,
    output logic [31:0]                   iss_v1,
    output logic [31:0]                   iss_v2,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          almost_full
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = IDX_W + 1;

    iq_entry_t                    r_ent [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0]  r_age;
    logic [CW-1:0]                r_count;
    logic                         r_full;
    logic                         r_af;

    iq_entry_t                    w_nxt [DEPTH];
    iq_entry_t                    w_disp_ent;
    iq_entry_t                    w_sel;
    logic [DEPTH-1:0][DEPTH-1:0]  w_age_nxt;
    logic [DEPTH-1:0]             w_ready;
    logic [DEPTH-1:0]             w_valid;
    logic [DEPTH-1:0]             w_oldest;
    logic                         w_any;
    logic [IDX_W-1:0]             w_free;
    logic                         w_disp_fire;
    logic                         w_iss_fire;
    logic [CW-1:0]                w_count_nxt;

    always_comb begin
        w_ready = '0;
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_ent[i].valid;
            w_ready[i] = r_ent[i].valid && !r_ent[i].has_dep1 && !r_ent[i].has_dep2;
        end
    end

    iq_age_select #(.DEPTH(DEPTH)) u_sel (
        .i_age    (r_age),
        .i_ready  (w_ready),
        .o_oldest (w_oldest),
        .o_any    (w_any)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_oldest[i]) w_sel = w_sel | r_ent[i];
    end

    assign iss_valid  = w_any && !flush_in;
    assign iss_type   = iss_valid ? w_sel.op     : '0;
    assign iss_rob_id = iss_valid ? w_sel.rob_id : '0;
    assign iss_v1     = iss_valid ? w_sel.v1     : '0;
    assign iss_v2     = iss_valid ? w_sel.v2     : '0;

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign disp_ready = !r_full && !flush_in;
`else
    assign disp_ready = !r_full && !flush_in && !(|cdb_valid);
`endif
    assign w_disp_fire = disp_valid && disp_ready;
    assign w_iss_fire  = iss_valid && iss_ready;
    assign w_count_nxt = r_count + CW'(w_disp_fire) - CW'(w_iss_fire);

    always_comb begin
        w_free = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!r_ent[i].valid) w_free = IDX_W'(i);
    end

    always_comb begin
        w_disp_ent          = '0;
        w_disp_ent.valid    = 1'b1;
        w_disp_ent.op       = disp_type;
        w_disp_ent.rob_id   = disp_rob_id;
        w_disp_ent.v1       = disp_v1;
        w_disp_ent.v2       = disp_v2;
        w_disp_ent.has_dep1 = disp_has_dep1;
        w_disp_ent.has_dep2 = disp_has_dep2;
        w_disp_ent.dep1     = disp_dep1;
        w_disp_ent.dep2     = disp_dep2;
`ifdef ISSUE_QUEUE_BYPASS_EN
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && disp_has_dep1 && disp_dep1 == cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W]) begin
                w_disp_ent.has_dep1 = 1'b0;
                w_disp_ent.v1       = cdb_val[k*32 +: 32];
            end
            if (cdb_valid[k] && disp_has_dep2 && disp_dep2 == cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W]) begin
                w_disp_ent.has_dep2 = 1'b0;
                w_disp_ent.v2       = cdb_val[k*32 +: 32];
            end
        end
`endif
    end

    // Descending port scan so the lowest matching port is applied last.
    always_comb begin
        w_nxt     = r_ent;
        w_age_nxt = r_age;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && r_ent[i].has_dep1 && r_ent[i].dep1 == cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W]) begin
                    w_nxt[i].has_dep1 = 1'b0;
                    w_nxt[i].v1       = cdb_val[k*32 +: 32];
                end
                if (cdb_valid[k] && r_ent[i].has_dep2 && r_ent[i].dep2 == cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W]) begin
                    w_nxt[i].has_dep2 = 1'b0;
                    w_nxt[i].v2       = cdb_val[k*32 +: 32];
                end
            end
            if (w_iss_fire && w_oldest[i]) w_nxt[i].valid = 1'b0;
            if (w_disp_fire && w_free == IDX_W'(i)) begin
                w_nxt[i] = w_disp_ent;
                for (int j = 0; j < DEPTH; j++) w_age_nxt[j][i] = 1'b0;
                w_age_nxt[i] = w_valid;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_age   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
        end else if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
        end else begin
            r_ent   <= w_nxt;
            r_age   <= w_age_nxt;
            r_count <= w_count_nxt;
            r_full  <= w_count_nxt == CW'(DEPTH);
            r_af    <= w_count_nxt >= CW'(DEPTH - AF_MARGIN);
        end
    end

    assign count       = r_count;
    assign full        = r_full;
    assign almost_full = r_af;
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed self-checking bench for issue_queue (default parameters).
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in, flush_in;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_type;
    logic [4:0]  disp_rob_id, disp_dep1, disp_dep2;
    logic [31:0] disp_v1, disp_v2;
    logic        disp_has_dep1, disp_has_dep2;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_rob_id;
    logic [63:0] cdb_val;
    logic        iss_valid, iss_ready;
    logic [5:0]  iss_type;
    logic [4:0]  iss_rob_id;
    logic [31:0] iss_v1, iss_v2;
    logic [3:0]  count;
    logic        full, almost_full;

    int n_cmp = 0;
    int n_bad = 0;

    issue_queue dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_type(disp_type),
        .disp_rob_id(disp_rob_id), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_dep1(disp_dep1), .disp_dep2(disp_dep2),
        .disp_has_dep1(disp_has_dep1), .disp_has_dep2(disp_has_dep2),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_type(iss_type),
        .iss_rob_id(iss_rob_id), .iss_v1(iss_v1), .iss_v2(iss_v2),
        .count(count), .full(full), .almost_full(almost_full)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive(input logic [4:0] rob, input logic [31:0] a, input logic [31:0] b,
                         input logic h1, input logic [4:0] d1, input logic h2, input logic [4:0] d2);
        disp_valid    = 1'b1;
        disp_type     = OP_ADD;
        disp_rob_id   = rob;
        disp_v1       = a;
        disp_v2       = b;
        disp_has_dep1 = h1;
        disp_dep1     = d1;
        disp_has_dep2 = h2;
        disp_dep2     = d2;
    endtask

    task automatic put(input logic [4:0] rob, input logic [31:0] a, input logic [31:0] b,
                       input logic h1, input logic [4:0] d1, input logic h2, input logic [4:0] d2);
        drive(rob, a, b, h1, d1, h2, d2);
        cyc();
        disp_valid = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0; flush_in = 1'b0; disp_valid = 1'b0; disp_type = '0;
        disp_rob_id = '0; disp_v1 = '0; disp_v2 = '0; disp_dep1 = '0; disp_dep2 = '0;
        disp_has_dep1 = 1'b0; disp_has_dep2 = 1'b0; cdb_valid = '0; cdb_rob_id = '0;
        cdb_val = '0; iss_ready = 1'b0;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1 chk("rst_disp_ready", 32'(disp_ready), 1);

        // simple add, issued the cycle after dispatch
        iss_ready = 1'b1;
        put(5'd1, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("add_iss_valid", 32'(iss_valid), 1);
        chk("add_v1", iss_v1, 3);
        chk("add_v2", iss_v2, 4);
        chk("add_rob", 32'(iss_rob_id), 1);
        chk("add_count1", 32'(count), 1);
        cyc();
        iss_ready = 1'b0;
        #1;
        chk("add_count0", 32'(count), 0);
        chk("add_idle", 32'(iss_valid), 0);

        // wakeup from cdb port 1; the ready younger entry issues first
        put(5'd2, 32'd0, 32'd1, 1'b1, 5'd5, 1'b0, 5'd0);
        put(5'd3, 32'd7, 32'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("wk_first_rob", 32'(iss_rob_id), 3);
        cdb_valid = 2'b10; cdb_rob_id = {5'd5, 5'd9}; cdb_val = {32'h10, 32'h99};
        iss_ready = 1'b1;
        #1 chk("wk_no_forward", 32'(iss_rob_id), 3);
        cyc();
        cdb_valid = '0;
        #1;
        chk("wk_second_valid", 32'(iss_valid), 1);
        chk("wk_second_rob", 32'(iss_rob_id), 2);
        chk("wk_second_v1", iss_v1, 32'h10);
        chk("wk_second_v2", iss_v2, 1);
        cyc();
        iss_ready = 1'b0;
        #1 chk("wk_count0", 32'(count), 0);

        // both ports carry the same tag: port 0 wins
        put(5'd4, 32'd5, 32'd0, 1'b0, 5'd0, 1'b1, 5'd6);
        cdb_valid = 2'b11; cdb_rob_id = {5'd6, 5'd6}; cdb_val = {32'h22, 32'h21};
        cyc();
        cdb_valid = '0;
        #1;
        chk("port_pri_v2", iss_v2, 32'h21);
        chk("port_pri_v1", iss_v1, 5);
        iss_ready = 1'b1;
        cyc();
        iss_ready = 1'b0;

        // age order beats index order: slots 2,0,1 issue in dispatch order
        put(5'd10, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        put(5'd11, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        put(5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        iss_ready = 1'b1;
        #1 chk("age_y0", 32'(iss_rob_id), 10);
        cyc();
        #1 chk("age_y1", 32'(iss_rob_id), 11);
        cyc();
        iss_ready = 1'b0;
        put(5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        put(5'd14, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("age_count3", 32'(count), 3);
        iss_ready = 1'b1;
        #1 chk("age_slot2", 32'(iss_rob_id), 12);
        cyc();
        #1 chk("age_slot0", 32'(iss_rob_id), 13);
        cyc();
        #1 chk("age_slot1", 32'(iss_rob_id), 14);
        cyc();
        iss_ready = 1'b0;
        #1 chk("age_count0", 32'(count), 0);

        // fill with blocked entries
        for (int i = 0; i < 8; i++) begin
            put(5'(i), 32'd0, 32'd0, 1'b1, 5'(20 + i), 1'b0, 5'd0);
            #1;
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'(i + 1 >= 6));
            chk("fill_full", 32'(full), 32'(i + 1 == 8));
        end
        chk("fill_iss_valid", 32'(iss_valid), 0);
        drive(5'd30, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("ninth_ready", 32'(disp_ready), 0);
        cyc();
        #1 chk("ninth_count", 32'(count), 8);
        disp_valid = 1'b0;
        cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd20}; cdb_val = '0;
        cyc();
        cdb_valid = '0;
        disp_valid = 1'b1;
        iss_ready = 1'b1;
        #1;
        chk("full_iss_valid", 32'(iss_valid), 1);
        chk("full_iss_rob", 32'(iss_rob_id), 0);
        chk("full_no_reuse", 32'(disp_ready), 0);
        cyc();
        disp_valid = 1'b0;
        iss_ready = 1'b0;
        #1;
        chk("full_count7", 32'(count), 7);
        chk("full_clear", 32'(full), 0);
        chk("full_af7", 32'(almost_full), 1);
        flush_in = 1'b1;
        cyc();
        flush_in = 1'b0;
        #1;
        chk("flush7_count", 32'(count), 0);
        chk("flush7_af", 32'(almost_full), 0);

        // flush with five ready entries and a concurrent dispatch
        for (int i = 0; i < 5; i++) put(5'(i), 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("fl_count5", 32'(count), 5);
        flush_in = 1'b1;
        drive(5'd9, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        chk("fl_disp_ready", 32'(disp_ready), 0);
        chk("fl_iss_gated", 32'(iss_valid), 0);
        cyc();
        flush_in = 1'b0;
        disp_valid = 1'b0;
        #1;
        chk("fl_count0", 32'(count), 0);
        chk("fl_iss_valid", 32'(iss_valid), 0);

        // dispatch against a same-cycle broadcast
        drive(5'd15, 32'd0, 32'd2, 1'b1, 5'd7, 1'b0, 5'd0);
        cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd7}; cdb_val = {32'd0, 32'd9};
`ifdef ISSUE_QUEUE_BYPASS_EN
        #1 chk("byp_ready", 32'(disp_ready), 1);
        cyc();
        disp_valid = 1'b0;
        cdb_valid = '0;
        #1;
        chk("byp_iss_valid", 32'(iss_valid), 1);
        chk("byp_v1", iss_v1, 9);
        iss_ready = 1'b1;
        cyc();
        iss_ready = 1'b0;
        #1 chk("byp_count0", 32'(count), 0);
`else
        #1 chk("nobyp_ready", 32'(disp_ready), 0);
        cyc();
        cdb_valid = '0;
        #1 chk("nobyp_count0", 32'(count), 0);
        cyc();
        disp_valid = 1'b0;
        #1;
        chk("nobyp_count1", 32'(count), 1);
        chk("nobyp_waits", 32'(iss_valid), 0);
        flush_in = 1'b1;
        cyc();
        flush_in = 1'b0;
`endif

        // asynchronous reset in the middle of handshakes
        put(5'd16, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        put(5'd17, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(5'd18, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        iss_ready = 1'b1;
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_iss_valid", 32'(iss_valid), 0);
        @(negedge clk_in);
        disp_valid = 1'b0;
        iss_ready = 1'b0;
        rst_n_in = 1'b1;
        cyc();
        #1;
        chk("arst_after_count", 32'(count), 0);
        chk("arst_after_iss", 32'(iss_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
